clock_set_controller: RTL

Time-setting controller for the 24-hour clock. Converts two debounced user buttons into a field-by-field edit sequence for hours, minutes and seconds. Issues a single-cycle load strobe with the edited time to the clock's `Set_time`/time-input path. Sits between the button debouncers and the clock core, and owns every write to the clock's time registers except reset.

---
 rtl/clock_pkg.sv | 38 +++
 rtl/wrap_field.sv | 31 +++
 rtl/clock_set_controller.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock time-setting controller.
package clock_pkg;

  localparam int HR_W   = 5;
  localparam int MS_W   = 6;
  localparam int HR_MAX = 23;
  localparam int MS_MAX = 59;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    SET_SEC = 3'd3,
    LOAD    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_HR   = 2'd1,
    FIELD_MIN  = 2'd2,
    FIELD_SEC  = 2'd3
  } field_t;

  // Field highlighted on the display for a given state.
  function automatic field_t field_of(input state_t s);
    case (s)
      SET_HR:  return FIELD_HR;
      SET_MIN: return FIELD_MIN;
      SET_SEC: return FIELD_SEC;
      default: return FIELD_NONE;
    endcase
  endfunction

  function automatic logic is_edit(input state_t s);
    return (s == SET_HR) || (s == SET_MIN) || (s == SET_SEC);
  endfunction

endpackage

// File: rtl/wrap_field.sv
// One editable time field: loads a value (out-of-range loads become 0),
// and steps up/down with wrap between 0 and MAX.
module wrap_field #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // Field register; load has priority, inc and dec are never both asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= (load_value > MAX_V) ? '0 : load_value;
    end else if (inc) begin
      value <= (value == MAX_V) ? '0 : value + W'(1);
    end else if (dec) begin
      value <= (value == '0) ? MAX_V : value - W'(1);
    end
  end

endmodule

// File: rtl/clock_set_controller.sv
// Button-driven edit sequencer for the 24-hour clock: captures the running
// time, lets the user edit hr/min/sec field by field, then strobes a load.
//
// state   | meaning
// --------+-----------------------------------------------
// RUN     | clock running, no edit in progress
// SET_HR  | editing hours
// SET_MIN | editing minutes
// SET_SEC | editing seconds
// LOAD    | one-cycle Set_time strobe, then back to RUN
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Mode_btn,
  input  logic            Inc_btn,
  input  logic            Dec_btn,
  input  logic [HR_W-1:0] Cur_hr,
  input  logic [MS_W-1:0] Cur_min,
  input  logic [MS_W-1:0] Cur_sec,
  output logic            Set_time,
  output logic [HR_W-1:0] Set_hr,
  output logic [MS_W-1:0] Set_min,
  output logic [MS_W-1:0] Set_sec,
  output logic [1:0]      Field_sel,
  output logic            Editing
);

  localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  state_t state, state_next;
  logic mode_q, inc_q, dec_q;
  logic mode_press, inc_press, dec_press, any_press;
  logic step_up, step_dn;
  logic capture, idle_clr, idle_inc;
  logic [IDLE_W-1:0] idle;

  assign mode_press = Mode_btn & ~mode_q;
  assign inc_press  = Inc_btn & ~inc_q;
  assign dec_press  = Dec_btn & ~dec_q;
  assign any_press  = mode_press | inc_press | dec_press;

  // Mode wins over Inc/Dec; Inc and Dec together cancel.
  assign step_up = inc_press & ~dec_press & ~mode_press;
  assign step_dn = dec_press & ~inc_press & ~mode_press;

  // Previous button levels for rising-edge detection.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mode_q <= 1'b0;
      inc_q  <= 1'b0;
      dec_q  <= 1'b0;
    end else begin
      mode_q <= Mode_btn;
      inc_q  <= Inc_btn;
      dec_q  <= Dec_btn;
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= RUN;
    else       state <= state_next;
  end

  // Next-state logic and idle-counter control.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    idle_clr   = 1'b0;
    idle_inc   = 1'b0;
    unique case (state)
      RUN: begin
        idle_clr = 1'b1;
        if (mode_press) begin
          state_next = SET_HR;
          capture    = 1'b1;
        end
      end
      SET_HR, SET_MIN, SET_SEC: begin
        if (any_press) begin
          idle_clr = 1'b1;
          if (mode_press) begin
            state_next = (state == SET_HR)  ? SET_MIN :
                         (state == SET_MIN) ? SET_SEC : LOAD;
          end
        end else if (idle == IDLE_LAST) begin
          state_next = RUN;
        end else begin
          idle_inc = 1'b1;
        end
      end
      LOAD: begin
        idle_clr   = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // Idle counter for abandoning an untouched edit.
  always_ff @(posedge Clk) begin
    if (Reset || idle_clr) idle <= '0;
    else if (idle_inc)     idle <= idle + IDLE_W'(1);
  end

  // Registered status outputs, decoded from the state being entered.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Set_time  <= 1'b0;
      Editing   <= 1'b0;
      Field_sel <= 2'd0;
    end else begin
      Set_time  <= (state_next == LOAD);
      Editing   <= is_edit(state_next);
      Field_sel <= field_of(state_next);
    end
  end

  wrap_field #(.W(HR_W), .MAX(HR_MAX)) u_hr (
    .clk        (Clk),
    .reset      (Reset),
    .load       (capture),
    .load_value (Cur_hr),
    .inc        (step_up && state == SET_HR),
    .dec        (step_dn && state == SET_HR),
    .value      (Set_hr)
  );

  wrap_field #(.W(MS_W), .MAX(MS_MAX)) u_min (
    .clk        (Clk),
    .reset      (Reset),
    .load       (capture),
    .load_value (Cur_min),
    .inc        (step_up && state == SET_MIN),
    .dec        (step_dn && state == SET_MIN),
    .value      (Set_min)
  );

  wrap_field #(.W(MS_W), .MAX(MS_MAX)) u_sec (
    .clk        (Clk),
    .reset      (Reset),
    .load       (capture),
    .load_value (Cur_sec),
    .inc        (step_up && state == SET_SEC),
    .dec        (step_dn && state == SET_SEC),
    .value      (Set_sec)
  );

endmodule
